// File: rtl/nn_pkg.sv
// nn_pkg: state encoding, SRAM/LUT address widths, default layer sizes and
// load-target codes shared by the nn_sequencer block.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_L1_STREAM = 3'd1,
    S_L1_WAIT   = 3'd2,
    S_SIG_WAIT  = 3'd3,
    S_L2_STREAM = 3'd4,
    S_L2_DRAIN  = 3'd5,
    S_FINISH    = 3'd6
  } nn_state_t;

  localparam int A1_W  = 18;
  localparam int A2_W  = 12;
  localparam int A3_W  = 10;
  localparam int A5_W  = 7;
  localparam int SEL_W = 7;

  localparam int N_IN_DEF  = 784;
  localparam int N_HID_DEF = 10;
  localparam int N_OUT_DEF = 10;

  localparam logic [1:0] LD_INPUT = 2'd0;
  localparam logic [1:0] LD_W1    = 2'd1;
  localparam logic [1:0] LD_W2    = 2'd2;
  localparam logic [1:0] LD_LUT   = 2'd3;

endpackage

// File: rtl/nn_seq_wait.sv
// nn_seq_wait: shared handshake wait counter; o_expired is high on the last
// permitted wait cycle (TIMEOUT cycles spent) so the FSM can abort on that edge.
module nn_seq_wait #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_restart,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // cycles spent in the current wait state, cleared outside waits and on re-entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (!i_run || i_restart) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_run && (r_cnt == LAST);

endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: drives SRAM addresses and MAC strobes through layer-1, sigmoid
// and per-output layer-2 passes. Define NN_SEQ_LOAD_EN to add the SRAM/LUT load port.
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int N_HID    = N_HID_DEF,
  parameter int N_OUT    = N_OUT_DEF,
  parameter int PIPE_LAT = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mac1_done,
  input  logic             sig_ready,
`ifdef NN_SEQ_LOAD_EN
  input  logic             ld_valid,
  input  logic [1:0]       ld_target,
  input  logic [A1_W-1:0]  ld_addr,
  output logic             ld_ready,
`endif
  output logic             we,
  output logic [A1_W-1:0]  address_1,
  output logic [A2_W-1:0]  address_2,
  output logic [A3_W-1:0]  address_3,
  output logic [A5_W-1:0]  address_5,
  output logic             mac1_start,
  output logic             mac2_start,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int O_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int D_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [A3_W-1:0]  LAST_IN  = A3_W'(N_IN - 1);
  localparam logic [SEL_W-1:0] LAST_HID = SEL_W'(N_HID - 1);
  localparam logic [O_W-1:0]   LAST_OUT = O_W'(N_OUT - 1);
  localparam logic [D_W-1:0]   LAST_DRN = D_W'(PIPE_LAT - 1);

  if (N_OUT * N_HID > 4096) begin : g_l2_range_chk
    $error("nn_sequencer: N_OUT*N_HID must not exceed 4096");
  end
  if (N_IN > 1024) begin : g_l1_range_chk
    $error("nn_sequencer: N_IN must not exceed 1024");
  end

  nn_state_t        r_state;
  logic             r_busy, r_done, r_err, r_mac1_start, r_mac2_start;
  logic [A1_W-1:0]  r_addr1;
  logic [A2_W-1:0]  r_addr2;
  logic [A3_W-1:0]  r_addr3;
  logic [SEL_W-1:0] r_sel;
  logic [O_W-1:0]   r_o;
  logic [D_W-1:0]   r_d;
  logic             w_go, w_in_wait, w_wait_restart, w_expired;

  assign w_in_wait      = (r_state == S_L1_WAIT) || (r_state == S_SIG_WAIT);
  assign w_wait_restart = (r_state == S_L1_WAIT) && mac1_done;

`ifdef NN_SEQ_LOAD_EN
  logic            r_we, r_start_pend, w_load;
  logic [A5_W-1:0] r_addr5;

  // busy is low exactly in IDLE, so loads are only taken while idle
  assign w_load    = ld_valid && !r_busy;
  assign w_go      = (r_state == S_IDLE) && !w_load && (start || r_start_pend);
  assign ld_ready  = !r_busy;
  assign we        = r_we;
  assign address_5 = r_addr5;
`else
  assign w_go      = (r_state == S_IDLE) && start;
  assign we        = 1'b0;
  assign address_5 = {A5_W{1'b0}};
`endif

  nn_seq_wait #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .i_run     (w_in_wait),
    .i_restart (w_wait_restart),
    .o_expired (w_expired)
  );

  // sequencing FSM; every output is a flop updated together with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mac1_start <= 1'b0;
      r_mac2_start <= 1'b0;
      r_addr1      <= 18'd0;
      r_addr2      <= 12'd0;
      r_addr3      <= 10'd0;
      r_sel        <= 7'd0;
      r_o          <= O_W'(0);
      r_d          <= D_W'(0);
`ifdef NN_SEQ_LOAD_EN
      r_we         <= 1'b0;
      r_addr5      <= 7'd0;
      r_start_pend <= 1'b0;
`endif
    end else begin
      r_done       <= 1'b0;
      r_mac1_start <= 1'b0;
      r_mac2_start <= 1'b0;
`ifdef NN_SEQ_LOAD_EN
      r_we         <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef NN_SEQ_LOAD_EN
          if (w_load) begin
            r_we         <= 1'b1;
            r_start_pend <= r_start_pend || start;
            case (ld_target)
              LD_INPUT: r_addr3 <= ld_addr[A3_W-1:0];
              LD_W1:    r_addr1 <= ld_addr;
              LD_W2:    r_addr2 <= ld_addr[A2_W-1:0];
              LD_LUT:   r_addr5 <= ld_addr[A5_W-1:0];
              default:  r_addr1 <= ld_addr;
            endcase
          end
`endif
          if (w_go) begin
            r_state <= S_L1_STREAM;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_addr1 <= 18'd0;
            r_addr3 <= 10'd0;
`ifdef NN_SEQ_LOAD_EN
            r_start_pend <= 1'b0;
`endif
          end
        end
        S_L1_STREAM: begin
          // first SRAM word lands one cycle after address 0
          r_mac1_start <= (r_addr3 == 10'd0);
          if (r_addr3 == LAST_IN) begin
            r_state <= S_L1_WAIT;
          end else begin
            r_addr3 <= r_addr3 + 10'd1;
            r_addr1 <= r_addr1 + 18'd1;
          end
        end
        S_L1_WAIT: begin
          if (mac1_done) begin
            r_state <= S_SIG_WAIT;
          end else if (w_expired) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        S_SIG_WAIT: begin
          if (sig_ready) begin
            r_state <= S_L2_STREAM;
            r_o     <= O_W'(0);
            r_sel   <= 7'd0;
            r_addr2 <= 12'd0;
          end else if (w_expired) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        S_L2_STREAM: begin
          r_mac2_start <= (r_sel == 7'd0);
          if (r_sel == LAST_HID) begin
            r_state <= S_L2_DRAIN;
            r_d     <= D_W'(0);
          end else begin
            r_sel   <= r_sel + 7'd1;
            r_addr2 <= r_addr2 + 12'd1;
          end
        end
        S_L2_DRAIN: begin
          if (r_d == LAST_DRN) begin
            if (r_o == LAST_OUT) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              // o*N_HID+h is contiguous across outputs, so address_2 just steps on
              r_o     <= r_o + O_W'(1);
              r_state <= S_L2_STREAM;
              r_sel   <= 7'd0;
              r_addr2 <= r_addr2 + 12'd1;
            end
          end else begin
            r_d <= r_d + D_W'(1);
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign address_1  = r_addr1;
  assign address_2  = r_addr2;
  assign address_3  = r_addr3;
  assign sel        = r_sel;
  assign mac1_start = r_mac1_start;
  assign mac2_start = r_mac2_start;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: per-cycle vector tables checked through a scoreboard queue,
// plus hand-written reset and load sequences (load part needs NN_SEQ_LOAD_EN).
module tb_nn_sequencer;

  localparam int N_IN = 4;
  localparam int N_HID = 3;
  localparam int N_OUT = 2;
  localparam int PL = 2;
  localparam int TO = 8;
  localparam int LAT = 1 + N_IN + 1 + 1 + N_OUT * (N_HID + PL) + 1;
  localparam int K_NOM = 0, K_SPUR = 1, K_TO1 = 2, K_TO2 = 3;

  typedef struct {
    logic start, md, sr;
    logic busy, done, err, m1, m2;
    logic chk_l1, chk_l2;
    logic [9:0]  a3;
    logic [17:0] a1;
    logic [11:0] a2;
    logic [6:0]  sel;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, mac1_done, sig_ready;
  logic we, mac1_start, mac2_start, busy, done, err;
  logic [17:0] address_1;
  logic [11:0] address_2;
  logic [9:0]  address_3;
  logic [6:0]  address_5, sel;
`ifdef NN_SEQ_LOAD_EN
  logic        ld_valid, ld_ready;
  logic [1:0]  ld_target;
  logic [17:0] ld_addr;
`endif

  int n_checks = 0;
  int n_err = 0;
  int row_idx = 0;
  int done_at = -1;
  vec_t vq[$];
  vec_t sb[$];
  vec_t mon_e;

  nn_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .PIPE_LAT(PL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .mac1_done(mac1_done), .sig_ready(sig_ready),
`ifdef NN_SEQ_LOAD_EN
    .ld_valid(ld_valid), .ld_target(ld_target), .ld_addr(ld_addr), .ld_ready(ld_ready),
`endif
    .we(we), .address_1(address_1), .address_2(address_2), .address_3(address_3),
    .address_5(address_5), .mac1_start(mac1_start), .mac2_start(mac2_start), .sel(sel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"}, -1, 32'(we), 32'd0);
    chk({tag, ".address_1"}, -1, 32'(address_1), 32'd0);
    chk({tag, ".address_2"}, -1, 32'(address_2), 32'd0);
    chk({tag, ".address_3"}, -1, 32'(address_3), 32'd0);
    chk({tag, ".address_5"}, -1, 32'(address_5), 32'd0);
    chk({tag, ".mac1_start"}, -1, 32'(mac1_start), 32'd0);
    chk({tag, ".mac2_start"}, -1, 32'(mac2_start), 32'd0);
    chk({tag, ".sel"}, -1, 32'(sel), 32'd0);
    chk({tag, ".busy"}, -1, 32'(busy), 32'd0);
    chk({tag, ".done"}, -1, 32'(done), 32'd0);
    chk({tag, ".err"}, -1, 32'(err), 32'd0);
  endtask

  // Row k: inputs sampled at start-relative edge k, expectations just after it.
  task automatic build(input int kind);
    vec_t v;
    vq.delete();
    for (int j = 0; j < N_IN; j++) begin
      v = '{default: '0};
      v.start = (j == 0); v.busy = 1'b1; v.chk_l1 = 1'b1;
      v.a3 = 10'(j); v.a1 = 18'(j); v.m1 = (j == 1);
      vq.push_back(v);
    end
    if (kind == K_TO1) begin
      for (int j = 0; j < TO; j++) begin
        v = '{default: '0}; v.busy = 1'b1; vq.push_back(v);
      end
    end else begin
      v = '{default: '0}; v.busy = 1'b1; vq.push_back(v);
      v = '{default: '0}; v.busy = 1'b1; v.md = 1'b1; vq.push_back(v);
      if (kind == K_TO2) begin
        for (int j = 1; j < TO; j++) begin
          v = '{default: '0}; v.busy = 1'b1; vq.push_back(v);
        end
      end else begin
        for (int o = 0; o < N_OUT; o++) begin
          for (int h = 0; h < N_HID; h++) begin
            v = '{default: '0}; v.busy = 1'b1; v.chk_l2 = 1'b1;
            v.sr = (o == 0 && h == 0);
            v.sel = 7'(h); v.a2 = 12'(o * N_HID + h); v.m2 = (h == 1);
            vq.push_back(v);
          end
          for (int d = 0; d < PL; d++) begin
            v = '{default: '0}; v.busy = 1'b1; vq.push_back(v);
          end
        end
        v = '{default: '0}; v.busy = 1'b1; v.done = 1'b1; vq.push_back(v);
      end
    end
    if (kind == K_TO1 || kind == K_TO2) begin
      for (int j = 0; j < 3; j++) begin
        v = '{default: '0}; v.err = 1'b1; vq.push_back(v);
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        v = '{default: '0}; vq.push_back(v);
      end
    end
    if (kind == K_SPUR) begin
      foreach (vq[n]) vq[n].sr = 1'b1;
      vq[2].start = 1'b1; vq[2].md = 1'b1;
      vq[N_IN + 4].start = 1'b1;
    end
  endtask

  task automatic run_table();
    row_idx = 0;
    done_at = -1;
    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      start = vq[n].start; mac1_done = vq[n].md; sig_ready = vq[n].sr;
      sb.push_back(vq[n]);
    end
    @(negedge clk);
    start = 1'b0; mac1_done = 1'b0; sig_ready = 1'b0;
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
  endtask

  // scoreboard consumer: compare each expected row one step after its edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("busy", row_idx, 32'(busy), 32'(mon_e.busy));
      chk("done", row_idx, 32'(done), 32'(mon_e.done));
      chk("err", row_idx, 32'(err), 32'(mon_e.err));
      chk("mac1_start", row_idx, 32'(mac1_start), 32'(mon_e.m1));
      chk("mac2_start", row_idx, 32'(mac2_start), 32'(mon_e.m2));
      chk("we", row_idx, 32'(we), 32'd0);
      chk("address_5", row_idx, 32'(address_5), 32'd0);
      if (mon_e.chk_l1) begin
        chk("address_3", row_idx, 32'(address_3), 32'(mon_e.a3));
        chk("address_1", row_idx, 32'(address_1), 32'(mon_e.a1));
      end
      if (mon_e.chk_l2) begin
        chk("sel", row_idx, 32'(sel), 32'(mon_e.sel));
        chk("address_2", row_idx, 32'(address_2), 32'(mon_e.a2));
      end
      if (done && done_at < 0) done_at = row_idx;
      row_idx++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mac1_done = 1'b0; sig_ready = 1'b0;
`ifdef NN_SEQ_LOAD_EN
    ld_valid = 1'b0; ld_target = 2'd0; ld_addr = 18'd0;
`endif
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    build(K_NOM);  run_table();
    chk("latency_nominal", -1, 32'(done_at + 2), 32'(LAT));
    build(K_TO1);  run_table();
    build(K_NOM);  run_table();
    build(K_TO2);  run_table();
    build(K_SPUR); run_table();
    chk("latency_spurious", -1, 32'(done_at + 2), 32'(LAT));

    // reset while streaming layer 2, then a clean run
    @(negedge clk);
    start = 1'b1; mac1_done = 1'b1; sig_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N_IN + 3) @(negedge clk);
    chk("midrun.busy", -1, 32'(busy), 32'd1);
    chk("midrun.sel", -1, 32'(sel), 32'd1);
    #2 reset = 1'b1;
    #1 chk_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b0; mac1_done = 1'b0; sig_ready = 1'b0;
    build(K_NOM); run_table();
    chk("latency_after_reset", -1, 32'(done_at + 2), 32'(LAT));

`ifdef NN_SEQ_LOAD_EN
    @(negedge clk);
    chk("ld_ready_idle", -1, 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_target = 2'd1; ld_addr = 18'h2ABCD;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("load.we", -1, 32'(we), 32'd1);
    chk("load.address_1", -1, 32'(address_1), 32'h2ABCD);
    @(negedge clk);
    chk("load.we_off", -1, 32'(we), 32'd0);
    chk("load.address_1_hold", -1, 32'(address_1), 32'h2ABCD);
    ld_valid = 1'b1; ld_target = 2'd3; ld_addr = 18'h00055; start = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; start = 1'b0;
    chk("lut.we", -1, 32'(we), 32'd1);
    chk("lut.address_5", -1, 32'(address_5), 32'h55);
    chk("lut.start_deferred", -1, 32'(busy), 32'd0);
    @(negedge clk);
    chk("deferred_start.busy", -1, 32'(busy), 32'd1);
    chk("deferred_start.we", -1, 32'(we), 32'd0);
    chk("ld_ready_busy", -1, 32'(ld_ready), 32'd0);
    for (int t = 0; t < 60 && busy; t++) @(negedge clk);
    chk("load_run_timeout.busy", -1, 32'(busy), 32'd0);
    chk("load_run_timeout.err", -1, 32'(err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/nn_sequencer.md
# nn_sequencer

Control sequencer that drives the neural-network datapath's SRAM addresses, MAC start pulses, hidden-layer mux select and write enable, replacing the externally driven test inputs. Consumes the datapath's `mac1_done` and `sig_ready` handshakes and steps through layer-1 accumulation, sigmoid activation and layer-2 accumulation for each output neuron. Sits beside the datapath top level, which is its sole responder.

## Interface
- `N_IN`, 784: layer-1 inputs per neuron (input SRAM depth used).
- `N_HID`, 10: hidden values fed to the layer-2 MAC via the mux.
- `N_OUT`, 10: output neurons.
- `PIPE_LAT`, 4: layer-2 MAC pipeline drain cycles.
- `TIMEOUT`, 1023: max cycles waiting on any handshake.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin one inference; sampled only in IDLE.
- `mac1_done` in 1: layer-1 MAC accumulation complete.
- `sig_ready` in 1: hidden sigmoid outputs valid.
- `we` out 1: SRAM/LUT write enable.
- `address_1` out 18: weight-1 SRAM address.
- `address_2` out 12: weight-2 SRAM address.
- `address_3` out 10: input SRAM address.
- `address_5` out 7: sigmoid LUT address.
- `mac1_start` out 1: layer-1 MAC start, one-cycle pulse.
- `mac2_start` out 1: layer-2 MAC start, one-cycle pulse.
- `sel` out 7: hidden mux select and layer-2 address.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at inference end.
- `err` out 1: sticky timeout flag; cleared by `start` or reset.

## Operation
- States: IDLE, L1_STREAM, L1_WAIT, SIG_WAIT, L2_STREAM, L2_DRAIN, FINISH.
- IDLE: `start` causes IDLE→L1_STREAM and clears `err`.
- L1_STREAM: counter `i` runs 0..N_IN-1. Drives `address_3`=i and `address_1`=i. At `i`=N_IN-1 goes to L1_WAIT.
- L1_WAIT: waits for `mac1_done`, then goes to SIG_WAIT.
- SIG_WAIT: waits for `sig_ready`, then goes to L2_STREAM.
- Layer 1 runs once per inference. The hidden values then stay stable at the sigmoid outputs.
- L2_STREAM: counter `h` runs 0..N_HID-1. Drives `sel`=h and `address_2`=o*N_HID+h, where `o` is the output counter. At `h`=N_HID-1 goes to L2_DRAIN.
- L2_DRAIN: waits PIPE_LAT cycles. If `o`<N_OUT-1, increments `o` and returns to L2_STREAM; otherwise goes to FINISH.
- FINISH: one cycle; `done`=1, then IDLE.
- Address arithmetic: unsigned. `address_2` is computed modulo 2^12. `N_OUT`*`N_HID` must be ≤4096 (checked at elaboration).
- Timeout: L1_WAIT or SIG_WAIT exceeding TIMEOUT cycles sets `err` and returns to IDLE. No `done` pulse in that case.
- `start` outside IDLE is ignored.
- `mac1_done`/`sig_ready` asserted outside their wait state are ignored; they are not latched.

## Timing
- Reset values: state IDLE; all addresses 0; `sel` 0; `we`, `mac1_start`, `mac2_start`, `busy`, `done`, `err` all 0.
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled.
- SRAM read latency is 1 cycle. `mac1_start` pulses the cycle after `address_3`=0 is presented, aligned with the first SRAM data.
- `mac2_start` pulses the cycle after `sel`=0 for each `o`.
- Layer-1 stream: N_IN cycles. Each layer-2 pass: N_HID+PIPE_LAT cycles.
- Total latency with zero-wait handshakes (handshake seen on the first wait cycle): 1+N_IN+1+1+N_OUT*(N_HID+PIPE_LAT)+1 cycles.
- Reset mid-operation: all outputs return to reset values asynchronously. No `done` pulse.
- `mac1_done` and `sig_ready` high in the same cycle during L1_WAIT: only `mac1_done` is consumed. `sig_ready` must still be high in SIG_WAIT to proceed.

## Configuration
- `NN_SEQ_LOAD_EN` defined: adds these ports:
  - `ld_valid` in 1.
  - `ld_target` in 2: 0=input, 1=weight1, 2=weight2, 3=LUT.
  - `ld_addr` in 18.
  - `ld_ready` out 1: high only in IDLE.
- A load is accepted when `ld_valid`&&`ld_ready`. The next cycle drives the selected address with `we`=1 for exactly one cycle.
- A `start` in the same cycle as a load is deferred one cycle.
- `NN_SEQ_LOAD_EN` undefined: load ports are absent, `we` is tied 0 and `address_5` is tied 0.

## Structure
- Package `nn_pkg`: state enum, address widths (18/12/10/7), default N_IN/N_HID/N_OUT, load-target codes.
- Sub-module `nn_seq_wait`: shared handshake-wait/timeout counter, instantiated once and restarted on each wait-state entry.

## Test plan
- **Nominal run.** N_IN=4, N_HID=3, N_OUT=2, PIPE_LAT=2, handshakes echoed 1 cycle after entering each wait state.
  - `address_3` sequence 0,1,2,3.
  - `address_2` sequence 0,1,2 then 3,4,5.
  - `mac2_start` pulses twice; one `done` pulse; `err`=0.
- **Timeout.** TIMEOUT=8, `mac1_done` never asserted → `err`=1 on the 9th L1_WAIT cycle, return to IDLE, `done` stays 0.
- **Mid-run reset.** Assert `reset` during L2_STREAM → all outputs 0 in the same cycle; a new `start` then runs to completion normally.
- **Spurious handshakes.** `start` pulses while busy, and `sig_ready` held high throughout → no restart, SIG_WAIT exits on its first cycle, and the cycle count matches the formula.
- **Load path.** With `NN_SEQ_LOAD_EN`, load `ld_target`=1, `ld_addr`=0x2ABCD → `address_1`=0x2ABCD with `we`=1 for exactly one cycle.
